// File: rtl/xlr8_servo_seq.sv
// rtl/xlr8_servo_seq.sv - servo keyframe playback sequencer and host/sequencer write arbiter (optional macro: XLR8_SERVO_SEQ_LOOP_EN)
module xlr8_servo_seq #(
    parameter int DEPTH      = 16,
    parameter int NUM_SERVOS = 12,
    parameter int PTR_W      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en1mhz,
    input  logic             tbl_we,
    input  logic [PTR_W-1:0] tbl_addr,
    input  logic [27:0]      tbl_wdata,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic [PTR_W-1:0] cur_ptr,
    input  logic             host_req,
    input  logic [4:0]       host_index,
    input  logic [11:0]      host_pw,
    output logic             host_gnt,
    output logic [4:0]       priv_index,
    output logic             priv_wr_pw,
    output logic [15:0]      priv_pw
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DWELL = 2'd3
    } state_t;

    localparam logic [9:0]       PRESC_MAX = 10'd999;
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);

    state_t           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [27:0]      ent_q, ent_d;
    logic [9:0]       presc_q, presc_d;
    logic [9:0]       dwell_q, dwell_d;
    logic             wr_q, wr_d;
    logic             gnt_q, gnt_d;
    logic [4:0]       idx_q, idx_d;
    logic [15:0]      pw_q, pw_d;
    logic             seq_wr;
    logic [27:0]      tbl_q [DEPTH];

    // Working entry fields: the loaded copy, so table rewrites do not disturb the current step
    logic       ent_last;
    logic [4:0] ent_chan;
    logic [11:0] ent_pw;
    logic [9:0] ent_dwell;
    logic       chan_ok;

    assign ent_last  = ent_q[27];
    assign ent_chan  = ent_q[26:22];
    assign ent_pw    = ent_q[21:10];
    assign ent_dwell = ent_q[9:0];
    assign chan_ok   = 32'(ent_chan) < NUM_SERVOS;

    // Keyframe table: plain storage, writable in any state, deliberately not reset
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            tbl_q[tbl_addr] <= tbl_wdata;
        end
    end

    // Sequencer state, pointer, working entry, timers and registered write port
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            ent_q   <= '0;
            presc_q <= '0;
            dwell_q <= '0;
            wr_q    <= 1'b0;
            gnt_q   <= 1'b0;
            idx_q   <= '0;
            pw_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ent_q   <= ent_d;
            presc_q <= presc_d;
            dwell_q <= dwell_d;
            wr_q    <= wr_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            pw_q    <= pw_d;
        end
    end

    // Next-state logic: playback stepping, ms dwell timing, stop override and write arbitration
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ent_d   = ent_q;
        presc_d = presc_q;
        dwell_d = dwell_q;
        seq_wr  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ptr_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                ent_d   = tbl_q[ptr_q];
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                // Host owns the port while requesting; the sequencer waits here
                if (!host_req) begin
                    seq_wr  = chan_ok;
                    presc_d = '0;
                    dwell_d = '0;
                    state_d = ST_DWELL;
                end
            end
            ST_DWELL: begin
                if (dwell_q == ent_dwell) begin
                    if (ent_last || (ptr_q == PTR_LAST)) begin
`ifdef XLR8_SERVO_SEQ_LOOP_EN
                        ptr_d   = '0;
                        state_d = ST_LOAD;
`else
                        state_d = ST_IDLE;
`endif
                    end else begin
                        ptr_d   = ptr_q + PTR_W'(1);
                        state_d = ST_LOAD;
                    end
                end else if (en1mhz) begin
                    if (presc_q == PRESC_MAX) begin
                        presc_d = '0;
                        dwell_d = dwell_q + 10'd1;
                    end else begin
                        presc_d = presc_q + 10'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Stop wins over everything; a write not yet registered is dropped
        if (stop) begin
            state_d = ST_IDLE;
            ptr_d   = '0;
            seq_wr  = 1'b0;
        end

        wr_d  = 1'b0;
        gnt_d = 1'b0;
        idx_d = idx_q;
        pw_d  = pw_q;
        if (host_req) begin
            wr_d  = 1'b1;
            gnt_d = 1'b1;
            idx_d = host_index;
            pw_d  = {4'h0, host_pw};
        end else if (seq_wr) begin
            wr_d  = 1'b1;
            idx_d = ent_chan;
            pw_d  = {4'h0, ent_pw};
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign cur_ptr    = ptr_q;
    assign host_gnt   = gnt_q;
    assign priv_wr_pw = wr_q;
    assign priv_index = idx_q;
    assign priv_pw    = pw_q;

endmodule
